// File: rtl/hack_ram_arbiter.sv
// Two-port round-robin arbiter in front of one synchronous HACK RAM bank.
// Port A (CPU data side) and port B (loader/DMA side) compete for a single
// access per cycle. Grants and RAM drive are combinational from the current
// requests and arbiter state. Read data comes back one cycle later and is
// qualified by a registered rvalid strobe. A port may lock the RAM across
// several accesses so that it can do an atomic read-modify-write.
module hack_ram_arbiter #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Port A
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic                  a_lock,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  // Port B
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic                  b_lock,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  // RAM side
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_load,
  output logic [ADDR_WIDTH-1:0] ram_address,
  input  logic [DATA_WIDTH-1:0] ram_out
);

  typedef enum logic [1:0] {
    ST_OPEN   = 2'd0,
    ST_LOCK_A = 2'd1,
    ST_LOCK_B = 2'd2
  } state_t;

  state_t r_state;
  logic   r_last;      // port granted most recently: 0 = A, 1 = B
  logic   r_a_rvalid;
  logic   r_b_rvalid;

  logic   w_a_win;
  logic   w_b_win;

  // Pick this cycle's winner. Held in reset, nobody wins so the RAM sees
  // no access and both grants stay low even if requests are present.
  always_comb begin
    w_a_win = 1'b0;
    w_b_win = 1'b0;
    if (rst_n) begin
      case (r_state)
        ST_OPEN: begin
          // On a tie the port that was not granted most recently wins.
          w_a_win = a_req & (~b_req | r_last);
          w_b_win = b_req & (~a_req | ~r_last);
        end
        ST_LOCK_A: w_a_win = a_req;
        ST_LOCK_B: w_b_win = b_req;
        default: begin
          w_a_win = 1'b0;
          w_b_win = 1'b0;
        end
      endcase
    end
  end

  assign a_gnt = w_a_win;
  assign b_gnt = w_b_win;

  // RAM control depends only on requests and state, never on ram_out.
  assign ram_load    = (w_a_win & a_we) | (w_b_win & b_we);
  assign ram_address = w_a_win ? a_addr  : (w_b_win ? b_addr  : '0);
  assign ram_data    = w_a_win ? a_wdata : (w_b_win ? b_wdata : '0);

  // Both ports see the raw RAM output; rvalid says whose data it is.
  assign a_rdata  = ram_out;
  assign b_rdata  = ram_out;
  assign a_rvalid = r_a_rvalid;
  assign b_rvalid = r_b_rvalid;

  // Lock state machine, round-robin history and read-return strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_OPEN;
      r_last     <= 1'b1;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
    end else begin
      // Writes return old data from the RAM, so only reads raise rvalid.
      r_a_rvalid <= w_a_win & ~a_we;
      r_b_rvalid <= w_b_win & ~b_we;

      if (w_a_win) begin
        r_last <= 1'b0;
      end else if (w_b_win) begin
        r_last <= 1'b1;
      end

      case (r_state)
        ST_OPEN: begin
          if (w_a_win && a_lock) begin
            r_state <= ST_LOCK_A;
          end else if (w_b_win && b_lock) begin
            r_state <= ST_LOCK_B;
          end
        end
        ST_LOCK_A: begin
          if (w_a_win && !a_lock) begin
            r_state <= ST_OPEN;
          end
        end
        ST_LOCK_B: begin
          if (w_b_win && !b_lock) begin
            r_state <= ST_OPEN;
          end
        end
        default: r_state <= ST_OPEN;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_ram_arbiter.sv
// Directed bench for hack_ram_arbiter with a behavioural 8-word HACK RAM
// (registered read, read-before-write) attached to the RAM pins.
module tb_hack_ram_arbiter;

  localparam int AW = 3;
  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic          a_req, a_we, a_lock;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_gnt, a_rvalid;
  logic [DW-1:0] a_rdata;
  logic          b_req, b_we, b_lock;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_gnt, b_rvalid;
  logic [DW-1:0] b_rdata;
  logic [DW-1:0] ram_data;
  logic          ram_load;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_out;

  logic [DW-1:0] mem [0:7];

  int total;
  int bad;

  hack_ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_data(ram_data), .ram_load(ram_load), .ram_address(ram_address), .ram_out(ram_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural HACK RAM: registered read returning the pre-write contents.
  always @(posedge clk) begin
    if (ram_load) mem[ram_address] <= ram_data;
    ram_out <= mem[ram_address];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_gnt(input string tag, input logic ea, input logic eb);
    chk({tag, "_a_gnt"}, {31'd0, a_gnt}, {31'd0, ea});
    chk({tag, "_b_gnt"}, {31'd0, b_gnt}, {31'd0, eb});
  endtask

  task automatic chk_rv(input string tag, input logic ea, input logic eb);
    chk({tag, "_a_rvalid"}, {31'd0, a_rvalid}, {31'd0, ea});
    chk({tag, "_b_rvalid"}, {31'd0, b_rvalid}, {31'd0, eb});
  endtask

  task automatic set_a(input logic req, input logic we, input logic lock,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    a_req = req; a_we = we; a_lock = lock; a_addr = addr; a_wdata = wdata;
  endtask

  task automatic set_b(input logic req, input logic we, input logic lock,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    b_req = req; b_we = we; b_lock = lock; b_addr = addr; b_wdata = wdata;
  endtask

  // Start a new cycle: step past the rising edge so inputs change mid-cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_a;
    total = 0;
    bad   = 0;
    for (int i = 0; i < 8; i++) mem[i] = 16'(i * 16'h0011);
    mem[2] = 16'h1234;

    // ---- Reset with both ports requesting: everything quiet ----
    rst_n = 1'b0;
    set_a(1, 0, 0, 3'd2, 16'h0);
    set_b(1, 0, 0, 3'd2, 16'h0);
    #2;
    chk_gnt("reset", 0, 0);
    chk_rv("reset", 0, 0);
    chk("reset_ram_load", {31'd0, ram_load}, 32'd0);
    chk("reset_ram_address", {29'd0, ram_address}, 32'd0);
    chk("reset_ram_data", {16'd0, ram_data}, 32'd0);
    $display("txn reset: gnt=%b%b rvalid=%b%b load=%b", a_gnt, b_gnt, a_rvalid, b_rvalid, ram_load);
    set_a(0, 0, 0, 3'd0, 16'h0);
    set_b(0, 0, 0, 3'd0, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- First tie goes to A, B follows ----
    next_cycle();
    set_a(1, 0, 0, 3'd2, 16'h0);
    set_b(1, 0, 0, 3'd2, 16'h0);
    #1;
    chk_gnt("tie1", 1, 0);
    chk("tie1_addr", {29'd0, ram_address}, 32'd2);
    $display("txn tie1: a_gnt=%b b_gnt=%b addr=%0d", a_gnt, b_gnt, ram_address);
    next_cycle();
    set_a(0, 0, 0, 3'd0, 16'h0);
    #1;
    chk_gnt("tie2", 0, 1);
    chk_rv("tie2", 1, 0);
    chk("tie2_a_rdata", {16'd0, a_rdata}, 32'h1234);
    $display("txn tie2: a_rvalid=%b a_rdata=%h b_gnt=%b", a_rvalid, a_rdata, b_gnt);
    next_cycle();
    set_b(0, 0, 0, 3'd0, 16'h0);
    #1;
    chk_rv("tie3", 0, 1);
    chk("tie3_b_rdata", {16'd0, b_rdata}, 32'h1234);
    $display("txn tie3: b_rvalid=%b b_rdata=%h", b_rvalid, b_rdata);

    // ---- A writes 0xBEEF to 5, B reads it back ----
    next_cycle();
    set_a(1, 1, 0, 3'd5, 16'hBEEF);
    #1;
    chk_gnt("wr", 1, 0);
    chk("wr_load", {31'd0, ram_load}, 32'd1);
    chk("wr_addr", {29'd0, ram_address}, 32'd5);
    chk("wr_data", {16'd0, ram_data}, 32'hBEEF);
    $display("txn write: load=%b addr=%0d data=%h", ram_load, ram_address, ram_data);
    next_cycle();
    set_a(0, 0, 0, 3'd0, 16'h0);
    set_b(1, 0, 0, 3'd5, 16'h0);
    #1;
    chk_gnt("rd5", 0, 1);
    chk_rv("rd5", 0, 0);
    $display("txn read5: b_gnt=%b a_rvalid=%b", b_gnt, a_rvalid);
    next_cycle();
    set_b(0, 0, 0, 3'd0, 16'h0);
    #1;
    chk_rv("rd5ret", 0, 1);
    chk("rd5ret_b_rdata", {16'd0, b_rdata}, 32'hBEEF);
    chk("rd5ret_load", {31'd0, ram_load}, 32'd0);
    $display("txn read5 return: b_rvalid=%b b_rdata=%h", b_rvalid, b_rdata);

    // ---- Contention: both read continuously, grants alternate A,B,... ----
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      set_a(1, 0, 0, 3'd2, 16'h0);
      set_b(1, 0, 0, 3'd5, 16'h0);
      #1;
      exp_a = (k % 2 == 0);
      chk_gnt("cont", exp_a, !exp_a);
      chk_rv("cont", (k > 0) && !exp_a, (k > 0) && exp_a);
      if (a_rvalid) chk("cont_a_rdata", {16'd0, a_rdata}, 32'h1234);
      if (b_rvalid) chk("cont_b_rdata", {16'd0, b_rdata}, 32'hBEEF);
      $display("txn cont%0d: gnt=%b%b rvalid=%b%b rdata=%h", k, a_gnt, b_gnt, a_rvalid, b_rvalid, ram_out);
    end
    next_cycle();
    set_a(0, 0, 0, 3'd0, 16'h0);
    set_b(0, 0, 0, 3'd0, 16'h0);
    #1;
    chk_rv("cont_tail", 0, 1);
    chk("cont_tail_b_rdata", {16'd0, b_rdata}, 32'hBEEF);
    $display("txn cont tail: b_rvalid=%b b_rdata=%h", b_rvalid, b_rdata);

    // ---- Lock: A read-modify-write on address 3 while B keeps asking ----
    next_cycle();
    set_a(1, 0, 1, 3'd3, 16'h0);
    set_b(1, 0, 0, 3'd3, 16'h0);
    #1;
    chk_gnt("lk_rd", 1, 0);
    $display("txn lock read: a_gnt=%b b_gnt=%b", a_gnt, b_gnt);
    next_cycle();
    set_a(0, 0, 0, 3'd0, 16'h0);
    #1;
    chk_gnt("lk_idle1", 0, 0);
    chk_rv("lk_idle1", 1, 0);
    chk("lk_idle1_a_rdata", {16'd0, a_rdata}, 32'h0033);
    $display("txn lock idle1: b_gnt=%b a_rvalid=%b a_rdata=%h", b_gnt, a_rvalid, a_rdata);
    next_cycle();
    #1;
    chk_gnt("lk_idle2", 0, 0);
    $display("txn lock idle2: b_gnt=%b", b_gnt);
    next_cycle();
    set_a(1, 1, 0, 3'd3, 16'h5A5A);
    #1;
    chk_gnt("lk_wr", 1, 0);
    chk("lk_wr_load", {31'd0, ram_load}, 32'd1);
    $display("txn lock write: a_gnt=%b b_gnt=%b load=%b", a_gnt, b_gnt, ram_load);
    next_cycle();
    set_a(0, 0, 0, 3'd0, 16'h0);
    #1;
    chk_gnt("lk_open", 0, 1);
    chk_rv("lk_open", 0, 0);
    $display("txn unlocked: b_gnt=%b", b_gnt);
    next_cycle();
    set_b(0, 0, 0, 3'd0, 16'h0);
    #1;
    chk_rv("lk_ret", 0, 1);
    chk("lk_ret_b_rdata", {16'd0, b_rdata}, 32'h5A5A);
    $display("txn lock result: b_rvalid=%b b_rdata=%h", b_rvalid, b_rdata);

    // ---- Reset in the cycle after a granted read ----
    next_cycle();
    set_a(1, 0, 0, 3'd2, 16'h0);
    #1;
    chk_gnt("mr_rd", 1, 0);
    next_cycle();
    set_a(0, 0, 0, 3'd0, 16'h0);
    rst_n = 1'b0;
    #1;
    chk_rv("mr_rst", 0, 0);
    $display("txn mid-read reset: a_rvalid=%b", a_rvalid);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    set_a(1, 0, 0, 3'd1, 16'h0);
    set_b(1, 0, 0, 3'd1, 16'h0);
    #1;
    chk_gnt("mr_tie", 1, 0);
    $display("txn post-reset tie: gnt=%b%b", a_gnt, b_gnt);

    // ---- Reset also drops a held lock ----
    next_cycle();
    set_a(0, 0, 0, 3'd0, 16'h0);
    set_b(1, 1, 1, 3'd6, 16'h0066);
    #1;
    chk_gnt("lb_wr", 0, 1);
    next_cycle();
    set_b(0, 0, 0, 3'd0, 16'h0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    set_a(1, 0, 0, 3'd6, 16'h0);
    #1;
    chk_gnt("lb_clr", 1, 0);
    $display("txn lock cleared by reset: a_gnt=%b", a_gnt);
    next_cycle();
    set_a(0, 0, 0, 3'd0, 16'h0);
    #1;
    chk_rv("lb_ret", 1, 0);
    chk("lb_ret_a_rdata", {16'd0, a_rdata}, 32'h0066);

    // ---- Idle: nothing moves ----
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      #1;
      chk("idle_load", {31'd0, ram_load}, 32'd0);
      chk_gnt("idle", 0, 0);
      chk_rv("idle", 0, 0);
      $display("txn idle%0d: load=%b gnt=%b%b rvalid=%b%b", k, ram_load, a_gnt, b_gnt, a_rvalid, b_rvalid);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hack_ram_arbiter.md
# hack_ram_arbiter

Two-port round-robin arbiter that shares one synchronous HACK RAM bank (registered read, one-cycle read latency, read-before-write) between two requesters, port A (CPU data side) and port B (loader/DMA side). It sits directly in front of the RAM's `data`/`load`/`address`/`out` pins. It grants at most one access per cycle and returns read data with a `rvalid` strobe. It also supports a lock so one port can own the RAM for an atomic read-modify-write sequence.

## Interface
- `ADDR_WIDTH`, default 3: RAM address width; 3 matches the 8-word bank, larger values are used for bigger banks.
- `DATA_WIDTH`, default 16: word width.
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `a_req`, in, 1: port A requests an access. The port holds `a_req`, `a_we`, `a_addr` and `a_wdata` stable until `a_gnt`.
- `a_we`, in, 1: 1 means write, 0 means read.
- `a_lock`, in, 1: sampled when A is granted; requests exclusive ownership after this access.
- `a_addr`, in, ADDR_WIDTH: word address.
- `a_wdata`, in, DATA_WIDTH: write data.
- `a_gnt`, out, 1: access accepted this cycle (combinational from the current inputs and state).
- `a_rvalid`, out, 1: read data valid on `a_rdata` this cycle.
- `a_rdata`, out, DATA_WIDTH: read data; equal to `ram_out` and meaningful only while `a_rvalid` is high.
- `b_req`, `b_we`, `b_lock`, `b_addr`, `b_wdata`, `b_gnt`, `b_rvalid`, `b_rdata`: same as the A signals, for port B.
- `ram_data`, out, DATA_WIDTH: write data to RAM.
- `ram_load`, out, 1: write enable to RAM.
- `ram_address`, out, ADDR_WIDTH: RAM address.
- `ram_out`, in, DATA_WIDTH: RAM registered read output.

## Operation
- **State machine.** States are OPEN, LOCK_A and LOCK_B. Reset state is OPEN.
- **Winner selection.** Within a cycle, a single winner W is chosen as follows:
  - OPEN, one requester: that requester wins.
  - OPEN, both requesting: the port not granted most recently wins. The `last` register resets to B, so A wins the first tie.
  - LOCK_A: only A can win. B is not granted even if A is idle.
  - LOCK_B: only B can win, symmetrically.
- **Grant outputs.** `x_gnt` is 1 only for W. When there is no winner, both grants are 0.
- **RAM drive.** The RAM is driven combinationally from W: `ram_address` = W addr, `ram_data` = W wdata, `ram_load` = W we & grant. With no winner: `ram_load` = 0, `ram_address` = 0, `ram_data` = 0.
- **`last` update.** `last` updates to W on every grant.
- **Lock transitions.**
  - OPEN with W granted and `W_lock` = 1 goes to LOCK_W.
  - LOCK_W with W granted and `W_lock` = 0 goes to OPEN.
  - LOCK_W with no grant stays in LOCK_W.
- **Read return.**
  - A granted read (`we` = 0) sets registered `x_rvalid` for exactly the next cycle.
  - The RAM output during that cycle is the read result, passed through to `x_rdata`.
  - Writes produce no `rvalid`; `x_gnt` is the write acknowledge.
- **Read-before-write.** The RAM returns old data on a write cycle. The arbiter ignores `ram_out` on those cycles and raises no `rvalid`.
- **Back-to-back accesses.** A port may re-request in the cycle after its grant. A full-rate stream from one port is sustained at 1 access per cycle when the other port is idle.
- **Fairness.** In OPEN, with both ports requesting continuously, grants alternate A, B, A, B. The maximum wait is 1 cycle.
- **Both `rdata` outputs** are wired to `ram_out`. Consumers qualify the data with `rvalid`.

## Timing
- **Reset values:** all `gnt` = 0, all `rvalid` = 0, `ram_load` = 0, `ram_address` = 0, `ram_data` = 0, state = OPEN, `last` = B.
- **Reset mid-operation:** the asynchronous `rst_n` assertion clears any pending `rvalid` and any lock immediately. A read granted in the cycle before reset returns no `rvalid`.
- **Grant latency:** 0 cycles; `gnt` is in the same cycle as `req` when the port wins.
- **Read latency:** a read granted in cycle N gives `rvalid` and data in cycle N+1.
- **Write commit:** a write granted in cycle N is committed to the RAM at the rising edge ending cycle N. A read of the same address granted in cycle N+1 returns the new data in cycle N+2.
- **No combinational path** from `ram_out` to any `gnt` or RAM control output.
- **Locking port deasserts `req`:** the lock persists. The other port stalls indefinitely until the locking port issues an access with `lock` = 0. This is the requesters' responsibility.

## Test plan
- **Reset:** drive `rst_n` = 0 with both `req` = 1 → all outputs 0. Release reset, then both request a read of address 2 holding 0x1234 → `a_gnt` = 1 in the first cycle; `a_rvalid` = 1 with `a_rdata` = 0x1234 next cycle; B is granted the following cycle.
- **Write then read:**
  - A writes 0xBEEF to address 5 in cycle N → `ram_load` = 1 and `ram_address` = 5 in N; no `a_rvalid` in N+1.
  - B reads address 5 in N+1 → `b_rvalid` = 1 with `b_rdata` = 0xBEEF in N+2.
- **Contention:** both ports request continuously for 6 cycles → grants A, B, A, B, A, B; `rvalid` follows each read grant by one cycle on the correct port only.
- **Lock:**
  - A reads address 3 with `a_lock` = 1 while B requests continuously → B not granted.
  - A idles 2 cycles → B still not granted.
  - A writes address 3 with `a_lock` = 0 → state OPEN; B granted the next cycle.
- **Mid-read reset:** A read granted in cycle N, `rst_n` low during N+1 → `a_rvalid` = 0 in N+1; state OPEN and `last` = B after release.
- **Idle:** no requests for 10 cycles → `ram_load` = 0 and no `gnt` or `rvalid` asserted.
